// File: rtl/reg_bank_if.sv
// Register-bank port bundle: one write port and two registered read ports,
// grouped so the datapath and the bank share a single connection.
interface reg_bank_if;
  logic        reg_write;
  logic [4:0]  read_reg1;
  logic [4:0]  read_reg2;
  logic [4:0]  write_reg;
  logic [31:0] write_data;
  logic [31:0] read_data1;
  logic [31:0] read_data2;

  // Datapath side: drives addresses/write data, receives operands.
  modport master (
    output reg_write,
    output read_reg1,
    output read_reg2,
    output write_reg,
    output write_data,
    input  read_data1,
    input  read_data2
  );

  // Register-bank side.
  modport slave (
    input  reg_write,
    input  read_reg1,
    input  read_reg2,
    input  write_reg,
    input  write_data,
    output read_data1,
    output read_data2
  );
endinterface

// File: rtl/reg_bank.sv
// reg_bank: 32 x 32-bit MIPS general-purpose register file.
// r0 reads as zero, one write port, two read ports with registered outputs
// and same-edge write-to-read bypass so a read never sees stale contents.
module reg_bank #(
  parameter logic [31:0] SP_RESET = 32'd227,
  parameter logic [31:0] RA_RESET = 32'd0
) (
  input  logic      clk,
  input  logic      reset_n,
  reg_bank_if.slave bus
);

  logic [31:0] regs_r [32];
  logic [31:0] read_data1_r;
  logic [31:0] read_data2_r;
  logic [31:0] rd1_s;
  logic [31:0] rd2_s;
  logic        wr_en_s;

  // Writes to address 0 are dropped here so r0 stays at its reset value of 0.
  always_comb begin
    wr_en_s = 1'b0;
    if (bus.reg_write && (bus.write_reg != 5'd0)) begin
      wr_en_s = 1'b1;
    end else begin
      wr_en_s = 1'b0;
    end
  end

  // Register array: reset to zero except $sp and $ra, then take the single write port.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 32; i++) begin
        regs_r[i] <= 32'd0;
      end
      regs_r[29] <= SP_RESET;
      regs_r[31] <= RA_RESET;
    end else begin
      for (int i = 1; i < 32; i++) begin
        if (wr_en_s && (bus.write_reg == 5'(i))) begin
          regs_r[i] <= bus.write_data;
        end else begin
          regs_r[i] <= regs_r[i];
        end
      end
    end
  end

  // Read-port 1 source: zero for r0, bypassed write data on an address hit, else the array.
  always_comb begin
    rd1_s = 32'd0;
    if (bus.read_reg1 == 5'd0) begin
      rd1_s = 32'd0;
    end else if (bus.reg_write && (bus.write_reg == bus.read_reg1)) begin
      rd1_s = bus.write_data;
    end else begin
      rd1_s = regs_r[bus.read_reg1];
    end
  end

  // Read-port 2 source: same selection as port 1.
  always_comb begin
    rd2_s = 32'd0;
    if (bus.read_reg2 == 5'd0) begin
      rd2_s = 32'd0;
    end else if (bus.reg_write && (bus.write_reg == bus.read_reg2)) begin
      rd2_s = bus.write_data;
    end else begin
      rd2_s = regs_r[bus.read_reg2];
    end
  end

  // Output operand registers feeding the A/B latches.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      read_data1_r <= 32'd0;
      read_data2_r <= 32'd0;
    end else begin
      read_data1_r <= rd1_s;
      read_data2_r <= rd2_s;
    end
  end

  assign bus.read_data1 = read_data1_r;
  assign bus.read_data2 = read_data2_r;

endmodule

// File: doc/reg_bank.md
# reg_bank

Register bank for the multicycle MIPS datapath: 32 general-purpose registers with two read ports and one write port. The write address is the 5-bit output of the write-register selector (rt, rd, $29 or $31), so this block is the consumer of that selection. Read ports take rs/rt from the instruction register and return registered operands that feed the A/B latches and the ALU-source muxes.

## Interface
- SP_RESET, 32'd227: reset value of register 29 ($sp)
- RA_RESET, 32'd0: reset value of register 31 ($ra)
- clk  in  1  rising-edge clock
- reset_n  in  1  asynchronous, active-low reset
- reg_write  in  1  write enable from control unit
- read_reg1  in  5  rs address (instruction [25..21])
- read_reg2  in  5  rt address (instruction [20..16])
- write_reg  in  5  write address from write-register selector
- write_data  in  32  data from write-data selector (ALUOut, MDR, HI, LO, …)
- read_data1  out  32  registered contents of read_reg1
- read_data2  out  32  registered contents of read_reg2

## Operation
- Storage: 32 × 32-bit registers r0..r31.
- r0 hardwired to zero: writes to address 0 are discarded; reads of address 0 return 0 even on the bypass path.
- Write: on a rising edge with reg_write=1 and write_reg≠0, r[write_reg] ← write_data. With reg_write=0 no register changes.
- Read: on every rising edge, read_data1 ← value(read_reg1) and read_data2 ← value(read_reg2), where value(a) is:
  - 0 if a=0;
  - write_data if reg_write=1 and write_reg=a (write-to-read bypass, same edge);
  - r[a] otherwise.
- Both ports may address the same register; both return the same value.
- No other state; no state machine. Sequential elements are the 32-register array (r0 may be a constant) and the two output registers.

## Timing
- Reset (reset_n=0, asynchronous, effective immediately without a clock edge): all registers 0 except r29=SP_RESET and r31=RA_RESET; read_data1=read_data2=0. Held while reset_n=0; clock edges ignored.
- Reset release: first rising edge with reset_n=1 performs normal write/read.
- Reset asserted mid-operation (including the cycle a write is pending): the write is lost; post-reset values as above.
- Write latency: data is visible in r[] after the edge on which reg_write=1 is sampled.
- Read latency: 1 cycle; read_data reflects addresses sampled on the previous edge and is stable for the whole following cycle.
- Bypass: a read addressing the register being written on the same edge returns the new write_data, never the old contents.
- Inputs are sampled only on the rising edge; address/data changes between edges have no effect.

## Test plan
- Reset: drive reset_n=0 mid-cycle with no clock edge -> read_data1/2=0 immediately; after release, read_reg1=29, read_reg2=31, one edge -> read_data1=227, read_data2=0.
- Basic write/read: reg_write=1, write_reg=8, write_data=0xDEADBEEF for one edge; then reg_write=0, read_reg1=8 -> read_data1=0xDEADBEEF after one edge; read_reg2=9 -> 0.
- r0 protection: write_reg=0, write_data=0xFFFFFFFF, reg_write=1, read_reg1=0 same edge -> read_data1=0; next read of r0 -> 0.
- Bypass: r5=0x11111111; same edge reg_write=1, write_reg=5, write_data=0x22222222, read_reg1=read_reg2=5 -> both outputs 0x22222222 after that edge.
- Write-disable and selector targets: reg_write=0, write_reg=31, write_data=0x1234 -> r31 stays 0; reg_write=1, write_reg=31, write_data=0x00400008 -> read of 31 returns 0x00400008; write_reg=29, write_data=0x200 -> read of 29 returns 0x200.
- Reset mid-operation: after the previous writes, pulse reset_n low between edges -> outputs 0 at once; subsequent reads: r5=0, r8=0, r29=227, r31=0.
